pll_reset_seq: RTL and testbench

//  Reset/lock sequencer placed beside the PLL wrapper. Runs on the free-running PLL input clock.

---
 rtl/pll_reset_pkg.sv | 29 ++
 rtl/pll_reset_seq_sync_2ff.sv | 27 ++
 rtl/pll_reset_seq.sv | 193 +++++++++++++++++++
 tb/tb_pll_reset_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared constants and helpers for the PLL reset/lock sequencer.
package pll_reset_pkg;

  localparam logic [2:0] ST_RESET_PLL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_PWRDN     = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  localparam logic [7:0] LOCK_LOSS_SAT = 8'hFF;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOCK_LOSS_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a quasi-static signal entering the CLK domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for stable lock, retries on
// timeout, and gates the downstream system reset on a synchronized lock.
module pll_reset_seq #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int RETRY_LIMIT         = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwrdwn_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  import pll_reset_pkg::*;

  localparam int PULSE_W = clog2_w(RST_PULSE_CYCLES);
  localparam int TOUT_W  = clog2_w(LOCK_TIMEOUT_CYCLES);
  localparam int STAB_W  = clog2_w(LOCK_STABLE_CYCLES);
  localparam int PT_W    = (PULSE_W > TOUT_W) ? PULSE_W : TOUT_W;
  localparam int TMR_W   = (PT_W > STAB_W) ? PT_W : STAB_W;

  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAB_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM  = 4'(RETRY_LIMIT);

  logic             locked_s;
  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;
  logic [3:0]       retry_inc_s;
  logic [3:0]       retry_nxt_s;
  logic [7:0]       loss_nxt_s;
  logic             pll_rst_nxt_s;
  logic             pll_pwrdwn_nxt_s;
  logic             sys_rst_nxt_s;
  logic             ready_nxt_s;
  logic             fail_nxt_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign retry_inc_s = retry_cnt + 4'd1;

  // Next-state and counter update; power-down preempts everything but FAIL.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_cnt;
    loss_nxt_s  = lock_loss_cnt;
    if (pwrdwn_req && (state_r != ST_FAIL)) begin
      state_nxt_s = ST_PWRDN;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (timer_r == PULSE_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else begin
            state_nxt_s = ST_RESET_PLL;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt_s = ST_STABLE;
          end else if (timer_r == TOUT_LAST) begin
            retry_nxt_s = retry_inc_s;
            if (retry_inc_s >= RETRY_LIM) begin
              state_nxt_s = ST_FAIL;
            end else begin
              state_nxt_s = ST_RESET_PLL;
            end
          end else begin
            state_nxt_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (timer_r == STAB_LAST) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            loss_nxt_s  = sat_inc8(lock_loss_cnt);
            state_nxt_s = ST_RESET_PLL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PWRDN: begin
          if (!pwrdwn_req) begin
            state_nxt_s = ST_RESET_PLL;
            retry_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_PWRDN;
          end
        end
        ST_FAIL: begin
          state_nxt_s = ST_FAIL;
        end
        default: begin
          state_nxt_s = ST_RESET_PLL;
        end
      endcase
    end
  end

  // Shared timer: cleared on every state change, only runs in timed states.
  always_comb begin
    timer_nxt_s = '0;
    if (state_nxt_s != state_r) begin
      timer_nxt_s = '0;
    end else if ((state_r == ST_RESET_PLL) || (state_r == ST_WAIT_LOCK) ||
                 (state_r == ST_STABLE)) begin
      timer_nxt_s = timer_r + TMR_W'(1);
    end else begin
      timer_nxt_s = '0;
    end
  end

  // Output decode from the upcoming state so outputs register alongside it.
  always_comb begin
    pll_rst_nxt_s    = 1'b1;
    pll_pwrdwn_nxt_s = 1'b0;
    sys_rst_nxt_s    = 1'b1;
    ready_nxt_s      = 1'b0;
    fail_nxt_s       = 1'b0;
    case (state_nxt_s)
      ST_RESET_PLL: begin
        pll_rst_nxt_s = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_rst_nxt_s = 1'b0;
      end
      ST_RUN: begin
        pll_rst_nxt_s = 1'b0;
        sys_rst_nxt_s = 1'b0;
        ready_nxt_s   = 1'b1;
      end
      ST_PWRDN: begin
        pll_pwrdwn_nxt_s = 1'b1;
      end
      ST_FAIL: begin
        fail_nxt_s = 1'b1;
      end
      default: begin
        pll_rst_nxt_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RESET_PLL;
      timer_r       <= '0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      pll_pwrdwn    <= 1'b0;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      retry_cnt     <= retry_nxt_s;
      lock_loss_cnt <= loss_nxt_s;
      pll_rst       <= pll_rst_nxt_s;
      pll_pwrdwn    <= pll_pwrdwn_nxt_s;
      sys_rst       <= sys_rst_nxt_s;
      ready         <= ready_nxt_s;
      fail          <= fail_nxt_s;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: directed scenarios plus random lock/power-down
// traffic, each cycle checked against a countdown-based reference model.
module tb_pll_reset_seq;

  localparam int P_PULSE = 4;
  localparam int P_TOUT  = 32;
  localparam int P_STAB  = 8;
  localparam int P_RETRY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwrdwn_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, pll_pwrdwn, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [16:0] dut_vec;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .RST_PULSE_CYCLES    (P_PULSE),
    .LOCK_TIMEOUT_CYCLES (P_TOUT),
    .LOCK_STABLE_CYCLES  (P_STAB),
    .RETRY_LIMIT         (P_RETRY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pwrdwn_req    (pwrdwn_req),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .pll_pwrdwn    (pll_pwrdwn),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  assign dut_vec = {pll_rst, pll_pwrdwn, sys_rst, ready, fail, retry_cnt, lock_loss_cnt};

  typedef enum {PH_PULSE, PH_AWAIT, PH_SETTLE, PH_UP, PH_OFF, PH_DEAD} phase_e;

  phase_e      ph = PH_PULSE;
  int          left = P_PULSE;
  int          retries = 0;
  int          losses = 0;
  bit          seen0 = 1'b0;
  bit          seen1 = 1'b0;
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference: lock is seen two samples late; phases count down their remaining cycles.
  function automatic void model_step(input bit r, input bit req, input bit lk);
    bit ls;
    if (r) begin
      ph = PH_PULSE; left = P_PULSE; retries = 0; losses = 0;
      seen0 = 1'b0; seen1 = 1'b0;
      return;
    end
    ls = seen1;
    seen1 = seen0;
    seen0 = lk;
    if (req && ph != PH_DEAD) begin
      ph = PH_OFF;
      return;
    end
    case (ph)
      PH_PULSE: begin
        left--;
        if (left == 0) begin ph = PH_AWAIT; left = P_TOUT; end
      end
      PH_AWAIT: begin
        if (ls) begin
          ph = PH_SETTLE; left = P_STAB;
        end else begin
          left--;
          if (left == 0) begin
            retries++;
            if (retries >= P_RETRY) ph = PH_DEAD;
            else begin ph = PH_PULSE; left = P_PULSE; end
          end
        end
      end
      PH_SETTLE: begin
        if (!ls) begin
          ph = PH_AWAIT; left = P_TOUT;
        end else begin
          left--;
          if (left == 0) begin ph = PH_UP; retries = 0; end
        end
      end
      PH_UP: begin
        if (!ls) begin
          if (losses < 255) losses++;
          ph = PH_PULSE; left = P_PULSE;
        end
      end
      PH_OFF: begin
        ph = PH_PULSE; left = P_PULSE; retries = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [16:0] model_out();
    logic [4:0] b;
    case (ph)
      PH_PULSE:  b = 5'b10100;
      PH_AWAIT:  b = 5'b00100;
      PH_SETTLE: b = 5'b00100;
      PH_UP:     b = 5'b00010;
      PH_OFF:    b = 5'b11100;
      default:   b = 5'b10101;
    endcase
    return {b, 4'(retries), 8'(losses)};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit req, input bit lk);
    @(negedge clk);
    rst = r; pwrdwn_req = req; pll_locked = lk;
    model_step(r, req, lk);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input int n, input bit r, input bit req, input bit lk);
    for (int i = 0; i < n; i++) step(r, req, lk);
  endtask

  // Samples the state produced by the most recent step's clock edge.
  task automatic expect_now(input string name, input logic [16:0] got_sel, input logic [16:0] exp);
    logic [16:0] g;
    @(posedge clk);
    #2;
    case (got_sel)
      17'd0:   g = {16'd0, ready};
      17'd1:   g = {16'd0, fail};
      17'd2:   g = {9'd0, lock_loss_cnt};
      default: g = dut_vec;
    endcase
    check(name, g, exp);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_vec, e);
      end
    end
  end

  initial begin
    int len;
    bit lk, req, r;

    // Power-up lock, then a one-cycle lock drop in RUN.
    hold(2, 1'b1, 1'b0, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    hold(30, 1'b0, 1'b0, 1'b1);
    expect_now("run_after_lock", 17'd0, 17'd1);
    step(1'b0, 1'b0, 1'b0);
    hold(40, 1'b0, 1'b0, 1'b1);
    expect_now("lock_loss_one", 17'd2, 17'd1);

    // Power-down from RUN and release.
    hold(20, 1'b0, 1'b1, 1'b1);
    hold(40, 1'b0, 1'b0, 1'b1);
    expect_now("lock_loss_after_pd", 17'd2, 17'd1);

    // Lock glitch during STABLE.
    hold(2, 1'b1, 1'b0, 1'b1);
    hold(5, 1'b0, 1'b0, 1'b1);
    hold(5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    hold(30, 1'b0, 1'b0, 1'b1);

    // Never locks: retries exhaust into FAIL, power-down ignored there.
    hold(2, 1'b1, 1'b0, 1'b0);
    hold(130, 1'b0, 1'b0, 1'b0);
    expect_now("fail_reached", 17'd1, 17'd1);
    hold(10, 1'b0, 1'b1, 1'b0);
    expect_now("fail_ignores_pd", 17'd1, 17'd1);

    // Lock-loss saturation, then reset while waiting for lock.
    hold(2, 1'b1, 1'b0, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b0, 1'b0);
      hold(20, 1'b0, 1'b0, 1'b1);
    end
    expect_now("lock_loss_sat", 17'd2, 17'h000FF);
    hold(10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_now("reset_values", 17'd3, {5'b10100, 4'd0, 8'd0});

    // Random traffic.
    step(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 80; s++) begin
      len = $urandom_range(1, 40);
      lk  = ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 24) == 0);
      if (r) step(1'b1, 1'b0, lk);
      hold(len, 1'b0, req, lk);
    end

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
